// File: rtl/lsu_byte_seq.sv
// Load/store sequencer for RAM port 2: splits byte/halfword requests into
// single-byte RAM accesses and returns a one-cycle response pulse.
module lsu_byte_seq #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [15:0]           req_wdata,
   output logic                  resp_valid,
   output logic [15:0]           resp_rdata,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_wdata,
   output logic                  ram_r_w,
   input  logic [7:0]            ram_rdata
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, RD_LAST, WR_LO, WR_HI} state_t;

   state_t                  state_q, state_d;
   logic                    req_ready_q, req_ready_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [15:0]             resp_rdata_q, resp_rdata_d;
   logic                    ram_en_q, ram_en_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]              ram_wdata_q, ram_wdata_d;
   logic                    ram_r_w_q, ram_r_w_d;
   logic                    size_q, size_d;
   logic                    signed_q, signed_d;
   logic [7:0]              wdata_hi_q, wdata_hi_d;
   logic [7:0]              lo_byte_q, lo_byte_d;

   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      ram_en_d     = ram_en_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_r_w_d    = ram_r_w_q;
      size_d       = size_q;
      signed_d     = signed_q;
      wdata_hi_d   = wdata_hi_q;
      lo_byte_d    = lo_byte_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            ram_en_d    = 1'b0;
            if (req_valid && req_ready_q) begin
               size_d      = req_size;
               signed_d    = req_signed;
               wdata_hi_d  = req_wdata[15:8];
               ram_addr_d  = req_addr;
               ram_en_d    = 1'b1;
               req_ready_d = 1'b0;
               ram_r_w_d   = req_we;
               if (req_we) begin
                  ram_wdata_d = req_wdata[7:0];
                  state_d     = WR_LO;
               end else begin
                  state_d     = RD_LO;
               end
            end
         end
         RD_LO: begin
            if (size_q) begin
               ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
               state_d    = RD_HI;
            end else begin
               ram_en_d   = 1'b0;
               state_d    = RD_LAST;
            end
         end
         RD_HI: begin
            lo_byte_d = ram_rdata;
            ram_en_d  = 1'b0;
            state_d   = RD_LAST;
         end
         RD_LAST: begin
            // Final byte arrives this cycle; byte loads extend it, halfwords pair it with the low byte.
            resp_valid_d = 1'b1;
            req_ready_d  = 1'b1;
            resp_rdata_d = size_q ? {ram_rdata, lo_byte_q}
                                  : {{8{signed_q & ram_rdata[7]}}, ram_rdata};
            state_d      = IDLE;
         end
         WR_LO: begin
            if (size_q) begin
               ram_addr_d  = ram_addr_q + ADDR_WIDTH'(1);
               ram_wdata_d = wdata_hi_q;
               state_d     = WR_HI;
            end else begin
               ram_en_d     = 1'b0;
               resp_valid_d = 1'b1;
               req_ready_d  = 1'b1;
               resp_rdata_d = 16'h0000;
               state_d      = IDLE;
            end
         end
         WR_HI: begin
            ram_en_d     = 1'b0;
            resp_valid_d = 1'b1;
            req_ready_d  = 1'b1;
            resp_rdata_d = 16'h0000;
            state_d      = IDLE;
         end
         default: begin
            ram_en_d    = 1'b0;
            req_ready_d = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 16'h0000;
         ram_en_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= 8'h00;
         ram_r_w_q    <= 1'b0;
         size_q       <= 1'b0;
         signed_q     <= 1'b0;
         wdata_hi_q   <= 8'h00;
         lo_byte_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         ram_en_q     <= ram_en_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_r_w_q    <= ram_r_w_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         wdata_hi_q   <= wdata_hi_d;
         lo_byte_q    <= lo_byte_d;
      end
   end

   // Reset kills the enable in the cycle it is asserted, so an in-flight write never reaches the RAM.
   assign ram_en     = ram_en_q & rst_n;
   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign ram_r_w    = ram_r_w_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed self-checking bench for lsu_byte_seq with a behavioural byte RAM
// on port 2 (registered read data, clocked only while ram_en is high).
module tb_lsu_byte_seq;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic          req_size;
   logic          req_signed;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_wdata;
   logic          resp_valid;
   logic [15:0]   resp_rdata;
   logic          ram_en;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic          ram_r_w;
   logic [7:0]    ram_rdata;

   logic [7:0]    mem [0:255];

   int compared   = 0;
   int mismatched = 0;
   int accepts    = 0;
   int resps      = 0;
   int writes     = 0;

   lsu_byte_seq #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .ram_en     (ram_en),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_r_w    (ram_r_w),
      .ram_rdata  (ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural RAM plus accept/response/write counters, all sampled on the active edge.
   always @(posedge clk) begin
      if (ram_en === 1'b1) begin
         if (ram_r_w === 1'b1) begin
            mem[ram_addr] <= ram_wdata;
            writes        <= writes + 1;
         end else begin
            ram_rdata     <= mem[ram_addr];
         end
      end
      if (rst_n === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1)
         accepts <= accepts + 1;
      if (resp_valid === 1'b1)
         resps <= resps + 1;
   end

   // Watchdog so the run always ends even if the design stalls the bench.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request at an idle negedge and checks every cycle up to and including
   // the response cycle; returns at the response-cycle negedge. With hold set, req_valid
   // stays high and the fields are scrambled while the request is in flight.
   task automatic applyStimulus(input string tag, input logic we, input logic size,
                                input logic sgn, input logic [7:0] addr,
                                input logic [15:0] wdata, input int lat,
                                input logic [15:0] exp, input logic hold);
      int         n_acc;
      logic [7:0] a1;
      n_acc = size ? 2 : 1;
      a1    = addr + 8'd1;
      checkOutput({tag, " ready_at_issue"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (hold) begin
               req_we     = ~we;
               req_size   = ~size;
               req_signed = ~sgn;
               req_addr   = ~addr;
               req_wdata  = ~wdata;
            end else begin
               req_valid  = 1'b0;
            end
         end
         checkOutput({tag, " ram_en"}, 32'(ram_en), 32'(k < n_acc));
         if (k < n_acc) begin
            checkOutput({tag, " ram_addr"}, 32'(ram_addr), 32'((k == 0) ? addr : a1));
            checkOutput({tag, " ram_r_w"}, 32'(ram_r_w), 32'(we));
         end
         checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'(k == lat));
         checkOutput({tag, " req_ready"}, 32'(req_ready), 32'(k == lat));
      end
      checkOutput({tag, " resp_rdata"}, 32'(resp_rdata), 32'(exp));
   endtask

   initial begin
      int base_acc;
      int base_resp;
      int base_wr;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 1'b0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = 16'h0000;

      // Reset held for two edges, then released; outputs must sit at reset values.
      @(negedge clk);
      checkOutput("rst ram_en c1", 32'(ram_en), 32'd0);
      @(negedge clk);
      checkOutput("rst ram_en c2", 32'(ram_en), 32'd0);
      checkOutput("rst req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst resp_rdata", 32'(resp_rdata), 32'd0);
      checkOutput("rst ram_addr", 32'(ram_addr), 32'd0);
      checkOutput("rst ram_wdata", 32'(ram_wdata), 32'd0);
      checkOutput("rst ram_r_w", 32'(ram_r_w), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst ram_en", 32'(ram_en), 32'd0);
      checkOutput("post_rst req_ready", 32'(req_ready), 32'd1);
      checkOutput("post_rst resp_valid", 32'(resp_valid), 32'd0);

      $display("[TB] halfword store/load at 0x10");
      applyStimulus("st_hw", 1'b1, 1'b1, 1'b0, 8'h10, 16'hBEEF, 2, 16'h0000, 1'b0);
      checkOutput("st_hw mem10", 32'(mem[8'h10]), 32'h0EF);
      checkOutput("st_hw mem11", 32'(mem[8'h11]), 32'h0BE);
      applyStimulus("ld_hw", 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 3, 16'hBEEF, 1'b0);
      @(negedge clk);
      checkOutput("ld_hw hold resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("ld_hw hold resp_rdata", 32'(resp_rdata), 32'h0BEEF);

      $display("[TB] byte store 0x80 at 0x20, signed and unsigned loads");
      applyStimulus("st_b", 1'b1, 1'b0, 1'b0, 8'h20, 16'h5580, 1, 16'h0000, 1'b0);
      checkOutput("st_b mem20", 32'(mem[8'h20]), 32'h080);
      applyStimulus("ld_bs", 1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, 2, 16'hFF80, 1'b0);
      applyStimulus("ld_bu", 1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, 2, 16'h0080, 1'b0);

      $display("[TB] halfword store/load wrapping at 0xFF");
      applyStimulus("st_wrap", 1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 2, 16'h0000, 1'b0);
      checkOutput("st_wrap memFF", 32'(mem[8'hFF]), 32'h034);
      checkOutput("st_wrap mem00", 32'(mem[8'h00]), 32'h012);
      applyStimulus("ld_wrap", 1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 3, 16'h1234, 1'b0);

      $display("[TB] back-to-back requests with req_valid held high");
      @(negedge clk);
      base_acc  = accepts;
      base_resp = resps;
      applyStimulus("b2b st_b30",  1'b1, 1'b0, 1'b0, 8'h30, 16'h007F, 1, 16'h0000, 1'b1);
      applyStimulus("b2b ld_bs30", 1'b0, 1'b0, 1'b1, 8'h30, 16'h0000, 2, 16'h007F, 1'b1);
      applyStimulus("b2b st_hw31", 1'b1, 1'b1, 1'b0, 8'h31, 16'hC3A5, 2, 16'h0000, 1'b1);
      applyStimulus("b2b ld_hw30", 1'b0, 1'b1, 1'b0, 8'h30, 16'h0000, 3, 16'hA57F, 1'b1);
      applyStimulus("b2b ld_hw31", 1'b0, 1'b1, 1'b1, 8'h31, 16'h0000, 3, 16'hC3A5, 1'b1);
      applyStimulus("b2b ld_bu32", 1'b0, 1'b0, 1'b0, 8'h32, 16'h0000, 2, 16'h00C3, 1'b1);
      applyStimulus("b2b ld_bs32", 1'b0, 1'b0, 1'b1, 8'h32, 16'h0000, 2, 16'hFFC3, 1'b1);
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("b2b trailing resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("b2b accept count", 32'(accepts - base_acc), 32'd7);
      checkOutput("b2b resp count", 32'(resps - base_resp), 32'd7);

      $display("[TB] reset during the high-byte write of a halfword store");
      applyStimulus("st_pre41", 1'b1, 1'b0, 1'b0, 8'h41, 16'h0077, 1, 16'h0000, 1'b0);
      @(negedge clk);
      base_wr   = writes;
      base_resp = resps;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 1'b1;
      req_signed = 1'b0;
      req_addr  = 8'h40;
      req_wdata = 16'hA55A;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_wr in WR_HI ram_addr", 32'(ram_addr), 32'h041);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_wr mem40", 32'(mem[8'h40]), 32'h05A);
      checkOutput("rst_wr mem41", 32'(mem[8'h41]), 32'h077);
      checkOutput("rst_wr write count", 32'(writes - base_wr), 32'd1);
      checkOutput("rst_wr resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_wr req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_wr ram_en", 32'(ram_en), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_wr after resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_wr resp count", 32'(resps - base_resp), 32'd0);
      applyStimulus("ld_hw40", 1'b0, 1'b1, 1'b0, 8'h40, 16'h0000, 3, 16'h775A, 1'b0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
Load/store sequencer directly upstream of port 2 of the dual-port byte-addressable data RAM. It accepts one byte or halfword load/store request at a time from the CPU execute stage. Each request is split into one or two byte accesses on the RAM port, and the result is returned as a one-cycle response pulse. The block also drives the RAM enable, which gates the RAM clock, so the RAM is clocked only while an access is in flight.

Parameters:
ADDR_WIDTH, 8, byte address width; addresses wrap modulo 2^ADDR_WIDTH.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept request this cycle
req_we  in  1  0 = load, 1 = store
req_size  in  1  0 = byte, 1 = halfword (little-endian)
req_signed  in  1  loads only: 1 = sign-extend byte load, 0 = zero-extend
req_addr  in  ADDR_WIDTH  byte address of low byte
req_wdata  in  16  store data; bits [7:0] only for byte store
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  16  load result, valid with resp_valid; 0 for stores
ram_en  out  1  to RAM en; high only in cycles that present an access
ram_addr  out  ADDR_WIDTH  to RAM port-2 address
ram_wdata  out  8  to RAM port-2 write data
ram_r_w  out  1  to RAM port-2 r/w (0 read, 1 write)
ram_rdata  in  8  from RAM port-2 data out; registered in RAM, valid the cycle after the address is sampled

Behaviour:
- All outputs are registered.
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; ram_en=0; ram_addr=0; ram_wdata=0; ram_r_w=0.
- Reset mid-operation: abort immediately, return to IDLE, no resp_valid, no further RAM writes.
- States: IDLE, RD_LO, RD_HI, RD_LAST, WR_LO, WR_HI.
- Accept: at the posedge where req_valid && req_ready. All request fields are captured then; later changes to them are ignored. req_ready=0 from the cycle after accept until the FSM returns to IDLE. req_valid while req_ready=0 has no effect.
- Read, halfword (accept at edge T):
  - RD_LO during T..T+1: ram_en=1, r_w=0, addr=A.
  - RD_HI during T+1..T+2: ram_en=1, addr=A+1. At edge T+2, capture low byte from ram_rdata.
  - RD_LAST during T+2..T+3: ram_en=0. At edge T+3, capture high byte.
  - resp_valid=1 during T+3..T+4. Load-to-response latency is 3 cycles.
- Read, byte: RD_LO, then RD_LAST (capture at T+2). resp_valid during T+2..T+3. Result is zero- or sign-extended per req_signed.
- Write, halfword: WR_LO (r_w=1, addr A, wdata[7:0]), then WR_HI (addr A+1, wdata[15:8]). resp_valid during T+2..T+3.
- Write, byte: WR_LO only. resp_valid during T+1..T+2.
- FSM is in IDLE with req_ready=1 in the same cycle resp_valid is high, so back-to-back requests are legal. A new accept in the response cycle starts its first RAM access in the following cycle.
- resp_rdata holds its value until the next load response. Stores drive resp_rdata=0 with their response.
- Address arithmetic: A+1 wraps modulo 2^ADDR_WIDTH, e.g. 0xFF -> 0x00. No misalignment fault; any address is legal.
- ram_en=0 in IDLE and RD_LAST; ram_addr and ram_wdata hold their last values when ram_en=0.
- req_signed is ignored for halfword loads and for all stores.
- No response backpressure: the consumer must take resp_valid when it pulses.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> all outputs equal reset values; req_ready=1; ram_en never asserted.
- Halfword store 0xBEEF to 0x10, then halfword load of 0x10 -> RAM writes 0xEF@0x10 and 0xBE@0x11; store resp 2 cycles after accept; load resp 3 cycles after accept with resp_rdata=0xBEEF.
- Byte store 0x80 to 0x20, then byte load of 0x20 with req_signed=1 and again with req_signed=0 -> loads return 0xFF80 and 0x0080; byte load resp 2 cycles after accept.
- Halfword store 0x1234 to 0xFF -> 0x34@0xFF, 0x12@0x00; halfword load of 0xFF returns 0x1234.
- Issue a request in every response cycle (back-to-back) with req_valid held high while busy -> exactly one accept per operation; ram_en pattern exactly as listed in Behaviour; no lost or duplicated response.
- Assert rst_n=0 during WR_HI of a halfword store -> no write to A+1, no resp_valid; IDLE and req_ready=1 on the next cycle.
